// File: rtl/ada_weak_lane.sv
//==============================================================================
// Module      : ada_weak_lane
// Description : One AdaBoost weak-learner lane. A 30-entry signed weight
//               store is loaded by the write strobe. The lane then computes
//               a dot product with a stream of ternary features, adds a bias
//               and emits a +/-1 prediction together with the signed class
//               vote.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ada_weak_lane (
    input  logic               clk,
    input  logic               rst,
    input  logic               write,
    input  logic               read,
    input  logic               en,
    input  logic [4:0]         address,
    input  logic signed [8:0]  weight,
    input  logic signed [1:0]  data,
    input  logic signed [8:0]  bias,
    input  logic signed [8:0]  class_weight,
    output logic               ready,
    output logic signed [1:0]  predict,
    output logic signed [9:0]  vote,
    output logic               err
);

    localparam logic [4:0] c_LAST_IDX = 5'd29;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARMED = 3'd2,
        S_ACCUM = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic signed [15:0] acc_q, acc_d;
    logic [4:0]         n_q, n_d;
    logic signed [1:0]  predict_q, predict_d;
    logic signed [9:0]  vote_q, vote_d;
    logic               err_q, err_d;

    // Weight store carries no reset: weights survive rst and are replaced only by loading.
    logic signed [8:0]  wmem_q [0:29];

    logic               w_addr_ok;
    logic signed [8:0]  w_cur_w;
    logic signed [15:0] w_wext;
    logic signed [15:0] w_term;
    logic signed [15:0] w_sum;
    logic signed [15:0] w_result;
    logic signed [9:0]  w_cw_ext;
    logic               w_bad_data;

    // Datapath: current weight times ternary feature, running sum and biased result.
    always_comb begin
        w_addr_ok  = (address <= c_LAST_IDX);
        w_cur_w    = wmem_q[n_q];
        w_wext     = {{7{w_cur_w[8]}}, w_cur_w};
        w_bad_data = (data == 2'b10);
        w_term     = 16'sd0;
        case (data)
            2'b01:   w_term = w_wext;
            2'b11:   w_term = -w_wext;
            default: w_term = 16'sd0;
        endcase
        w_sum    = acc_q + w_term;
        w_result = w_sum + {{7{bias[8]}}, bias};
        w_cw_ext = {class_weight[8], class_weight};
    end

    // Next-state and output logic for the load / arm / accumulate / done sequence.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        n_d       = n_q;
        predict_d = predict_q;
        vote_d    = vote_q;
        err_d     = err_q;
        ready     = 1'b0;

        if (write && !w_addr_ok) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    err_d = 1'b1;
                end
                if (write) begin
                    state_d = S_LOAD;
                end else if (read) begin
                    state_d = S_ARMED;
                end
            end

            S_LOAD: begin
                if (en) begin
                    err_d = 1'b1;
                end
                if (write) begin
                    state_d = S_LOAD;
                end else if (read) begin
                    state_d = S_ARMED;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ARMED, S_ACCUM: begin
                if (write) begin
                    // Reloading mid-stream discards the partial sum.
                    err_d   = 1'b1;
                    acc_d   = 16'sd0;
                    n_d     = 5'd0;
                    state_d = S_LOAD;
                end else if (en && (read || state_q == S_ACCUM)) begin
                    if (w_bad_data) begin
                        err_d = 1'b1;
                    end
                    acc_d = w_sum;
                    n_d   = n_q + 5'd1;
                    if (n_q == c_LAST_IDX) begin
                        // Prediction and vote are registered on entry to DONE so they
                        // are already valid during the ready pulse.
                        state_d   = S_DONE;
                        predict_d = w_result[15] ? -2'sd1 : 2'sd1;
                        vote_d    = w_result[15] ? -w_cw_ext : w_cw_ext;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else if (state_q == S_ARMED && !read) begin
                    state_d = S_IDLE;
                end
            end

            S_DONE: begin
                ready = 1'b1;
                acc_d = 16'sd0;
                n_d   = 5'd0;
                if (write) begin
                    state_d = S_LOAD;
                end else if (read) begin
                    state_d = S_ARMED;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= 16'sd0;
            n_q       <= 5'd0;
            predict_q <= 2'sd0;
            vote_q    <= 10'sd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            predict_q <= predict_d;
            vote_q    <= vote_d;
            err_q     <= err_d;
        end
    end

    // Weight store write port; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (!rst && write && w_addr_ok) begin
            wmem_q[address] <= weight;
        end
    end

    assign predict = predict_q;
    assign vote    = vote_q;
    assign err     = err_q;

endmodule

`default_nettype wire

// File: doc/ada_weak_lane.md
ADA_WEAK_LANE -- requirements
Module: ada_weak_lane

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: write  in  1  weight-load phase strobe; weight captured every cycle it is high.
REQ-004 SHALL have: read  in  1  lane armed for data streaming; sampled with en.
REQ-005 SHALL have: en  in  1  data-valid; one feature per cycle while high.
REQ-006 SHALL have: address  in  5  weight index during write; ignored otherwise.
REQ-007 SHALL have: weight  in  9 signed  weight value for address.
REQ-008 SHALL have: data  in  2 signed  feature value, legal {-1,0,+1}.
REQ-009 SHALL have: bias  in  9 signed  static bias, sampled at the finish cycle.
REQ-010 SHALL have: class_weight  in  9 signed  static AdaBoost vote weight.
REQ-011 SHALL have outputs: ready 1 (one-cycle done pulse), predict 2 signed (+1/-1, 0 before first result), vote 10 signed (predict x class_weight), err 1 (sticky protocol error).

Function
REQ-012 SHALL hold a 30-entry x 9-bit signed weight store; write=1 with address<30 SHALL write weight to entry address on that edge.
REQ-013 write=1 with address>=30 SHALL leave the store unchanged and set err.
REQ-014 SHALL implement states IDLE, LOAD, ARMED, ACCUM, DONE.
REQ-015 IDLE->LOAD on write=1; LOAD stays while write=1.
REQ-016 LOAD->ARMED on first cycle with write=0 and read=1; LOAD->IDLE on write=0 and read=0 (store retained).
REQ-017 IDLE->ARMED on read=1 with write=0 (reuse of previously loaded weights).
REQ-018 ARMED->ACCUM on the first cycle with en=1 and read=1; that cycle SHALL already process feature 0.
REQ-019 In ACCUM, each cycle with en=1 SHALL add weight[n]*data to a 16-bit signed accumulator and increment sample index n (5-bit, starts 0).
REQ-020 en=0 in ACCUM SHALL pause: accumulator and n held, no timeout.
REQ-021 data=2'b10 SHALL contribute 0, still advance n, and set err.
REQ-022 On the cycle processing n=29, the next state SHALL be DONE with result = acc_final + sign-extended bias computed from the accumulator including feature 29.
REQ-023 In DONE (exactly one cycle): predict <= +1 if result>=0 else -1; vote <= +class_weight or -class_weight (10-bit, -256 handled without overflow); ready=1; accumulator and n cleared.
REQ-024 DONE->ARMED if read=1, else ->IDLE; predict/vote SHALL hold until next DONE or reset.
REQ-025 Latency: ready asserts on the edge after the 30th en-qualified feature; minimum 31 cycles from first en.
REQ-026 write=1 while in ARMED or ACCUM SHALL abort accumulation (acc, n cleared), set err, enter LOAD and write the store as in REQ-012.
REQ-027 en=1 in IDLE or LOAD SHALL be ignored and set err.
REQ-028 err SHALL clear only on reset.
REQ-029 Accumulator width SHALL be sufficient: max |sum| = 30x256+256 = 7936, no saturation logic required.

Reset
REQ-030 rst=1 on an edge SHALL force IDLE, acc=0, n=0, ready=0, predict=0, vote=0, err=0, regardless of state, including mid-ACCUM.
REQ-031 Weight store contents SHALL NOT be cleared by reset (requires reload only by protocol).

Verification
REQ-032 Load all weights=+1 (address 0..29), read=1, 30 features data=+1, bias=0, class_weight=100 -> ready pulse after 30th feature, predict=+1, vote=+100.
REQ-033 Weights=+1, data all -1, bias=+29, class_weight=-5 -> result -1, predict=-1, vote=+5; repeat with bias=+30 -> result 0, predict=+1, vote=-5.
REQ-034 Stream 30 features with en low for 7 cycles after feature 12 -> same predict as uninterrupted run, ready delayed by exactly 7 cycles.
REQ-035 Assert rst at feature 15, then reload nothing, read=1, stream 30 features -> result uses retained weights, err=0, acc restarted from 0.
REQ-036 write=1 with address=30, then data=2'b10 on one feature -> err=1 and stays 1; store entries 0..29 unchanged; offending feature contributes 0.
REQ-037 Weights=-256, data=+1, bias=-256, class_weight=-256 -> result -7936 without wrap, predict=-1, vote=+256.
